// File: rtl/seg7_pkg.sv
//==============================================================================
// Module : seg7_pkg
// Brief  : Shared BCD/segment types and the active-low 7-segment lookup table.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

    // Bit order 6543210 = g..a, active low
    localparam seg_t SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic bcd_ok(input bcd_t d);
        return (d <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_digit_dec.sv
//==============================================================================
// Module : seg7_digit_dec
// Brief  : Combinational BCD digit to active-low 7-segment decoder with blanking.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module seg7_digit_dec
    import seg7_pkg::*;
(
    input  bcd_t digit,
    input  logic blank,
    output seg_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && bcd_ok(digit)) begin
            seg = SEG_LUT[digit];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg7_bcd_counter.sv
//==============================================================================
// Module : seg7_bcd_counter
// Brief  : N-digit BCD up/down counter with prescaler, load, wrap reporting and
//          registered active-low 7-segment outputs. Define SEG7_LZB_EN for
//          leading-zero blanking.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module seg7_bcd_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int STEP_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   leds,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] c_presc_last = PW'(STEP_DIV - 1);

`ifdef SEG7_LZB_EN
    localparam bit c_lzb = 1'b1;
`else
    localparam bit c_lzb = 1'b0;
`endif

    logic [4*DIGITS-1:0] r_count;
    logic [PW-1:0]       r_presc;
    logic                r_wrap;
    logic                r_load_err;

    logic [4*DIGITS-1:0] w_count_up;
    logic [4*DIGITS-1:0] w_count_dn;
    logic                w_carry;
    logic                w_borrow;
    logic                w_load_ok;
    logic                w_inc_only;
    logic                w_dec_only;
    logic                w_presc_hit;
    logic [DIGITS-1:0]   w_blank;
    logic                w_seen_nz;

    assign w_inc_only  = inc & ~dec;
    assign w_dec_only  = dec & ~inc;
    assign w_presc_hit = (r_presc == c_presc_last);

    // Ripple carry/borrow through the digits; a carry out of the top digit
    // leaves every digit at 0 (all 9s for borrow), which is exactly the wrap value.
    always_comb begin
        w_count_up = r_count;
        w_count_dn = r_count;
        w_carry    = 1'b1;
        w_borrow   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_carry) begin
                if (r_count[4*d +: 4] == 4'd9) begin
                    w_count_up[4*d +: 4] = 4'd0;
                end else begin
                    w_count_up[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_carry              = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*d +: 4] == 4'd0) begin
                    w_count_dn[4*d +: 4] = 4'd9;
                end else begin
                    w_count_dn[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                    w_borrow             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_load_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (!bcd_ok(load_val[4*d +: 4])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_presc    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (clear) begin
                r_count <= '0;
                r_presc <= '0;
            end else if (load) begin
                if (w_load_ok) begin
                    r_count <= load_val;
                    r_presc <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_inc_only || w_dec_only) begin
                if (w_presc_hit) begin
                    r_presc <= '0;
                    if (w_inc_only) begin
                        r_count <= w_count_up;
                        r_wrap  <= w_carry;
                    end else begin
                        r_count <= w_count_dn;
                        r_wrap  <= w_borrow;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    // Digit 0 is never blanked so a zero count still shows a single "0".
    always_comb begin
        w_blank   = '0;
        w_seen_nz = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_seen_nz  = w_seen_nz | (r_count[4*d +: 4] != 4'd0);
            w_blank[d] = c_lzb & ~w_seen_nz;
        end
    end

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            localparam seg_t c_seg_rst = (d == 0 || !c_lzb) ? SEG_ZERO : SEG_BLANK;

            seg_t w_seg;
            seg_t r_seg;

            seg7_digit_dec u_dec (
                .digit (r_count[4*d +: 4]),
                .blank (w_blank[d]),
                .seg   (w_seg)
            );

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_seg <= c_seg_rst;
                end else begin
                    r_seg <= w_seg;
                end
            end

            assign leds[7*d +: 7] = r_seg;
        end
    endgenerate

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_seg7_bcd_counter.sv
//==============================================================================
// Module : tb_seg7_bcd_counter
// Brief  : Scoreboard bench for seg7_bcd_counter (DIGITS=2, STEP_DIV 1 and 4).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_seg7_bcd_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic       wrap;
        logic       err;
    } exp_t;

    localparam logic [6:0] LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       clr_a, ld_a, inc_a, dec_a, wrap_a, err_a;
    logic [7:0] lv_a, cnt_a;
    logic [13:0] leds_a;
    logic       clr_b, ld_b, inc_b, dec_b, wrap_b, err_b;
    logic [7:0] lv_b, cnt_b;
    logic [13:0] leds_b;

    seg7_bcd_counter #(.DIGITS(2), .STEP_DIV(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clr_a), .load(ld_a), .load_val(lv_a),
        .inc(inc_a), .dec(dec_a), .count(cnt_a), .leds(leds_a), .wrap(wrap_a), .load_err(err_a)
    );

    seg7_bcd_counter #(.DIGITS(2), .STEP_DIV(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clr_b), .load(ld_b), .load_val(lv_b),
        .inc(inc_b), .dec(dec_b), .count(cnt_b), .leds(leds_b), .wrap(wrap_b), .load_err(err_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [13:0] model_leds(input logic [7:0] c);
        logic [6:0] lo;
        logic [6:0] hi;
        lo = LUT[c[3:0]];
        hi = LUT[c[7:4]];
`ifdef SEG7_LZB_EN
        if (c[7:4] == 4'd0) hi = 7'b1111111;
`endif
        return {hi, lo};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        {clr_a, ld_a, inc_a, dec_a} = 4'b0;
        {clr_b, ld_b, inc_b, dec_b} = 4'b0;
        lv_a = 8'h00;
        lv_b = 8'h00;
    endtask

    // sel=0 drives dut_a, sel=1 drives dut_b; expected response is queued.
    task automatic drv(input bit sel, input bit clr, input bit ld, input logic [7:0] lv,
                       input bit i, input bit d, input logic [7:0] ec, input bit ew, input bit ee);
        exp_t e;
        @(negedge clk);
        idle_all();
        e = '{cnt: ec, wrap: ew, err: ee};
        if (!sel) begin
            clr_a = clr; ld_a = ld; lv_a = lv; inc_a = i; dec_a = d;
            q_a.push_back(e);
        end else begin
            clr_b = clr; ld_b = ld; lv_b = lv; inc_b = i; dec_b = d;
            q_b.push_back(e);
        end
    endtask

    // Monitor: leds lag count by one cycle, so they are checked against the
    // previously expected count.
    logic [7:0] prev_a = 8'h00;
    logic [7:0] prev_b = 8'h00;
    exp_t       m_e;
    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            prev_a = 8'h00;
            prev_b = 8'h00;
        end else begin
            if (q_a.size() > 0) begin
                m_e = q_a.pop_front();
                check("a_count", {8'h0, cnt_a}, {8'h0, m_e.cnt});
                check("a_wrap", {15'h0, wrap_a}, {15'h0, m_e.wrap});
                check("a_load_err", {15'h0, err_a}, {15'h0, m_e.err});
                check("a_leds", {2'b0, leds_a}, {2'b0, model_leds(prev_a)});
                prev_a = m_e.cnt;
            end
            if (q_b.size() > 0) begin
                m_e = q_b.pop_front();
                check("b_count", {8'h0, cnt_b}, {8'h0, m_e.cnt});
                check("b_wrap", {15'h0, wrap_b}, {15'h0, m_e.wrap});
                check("b_load_err", {15'h0, err_b}, {15'h0, m_e.err});
                check("b_leds", {2'b0, leds_b}, {2'b0, model_leds(prev_b)});
                prev_b = m_e.cnt;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {8'h0, cnt_a}, 16'h0000);
        check("rst_wrap", {15'h0, wrap_a}, 16'h0000);
        check("rst_load_err", {15'h0, err_a}, 16'h0000);
        check("rst_leds", {2'b0, leds_a}, {2'b0, model_leds(8'h00)});
        @(negedge clk);
        reset_n = 1'b1;

        //  sel clr ld lv    inc dec  exp   wrap err
        drv(0, 0, 1, 8'h98, 0, 0, 8'h98, 0, 0);
        drv(0, 0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
        drv(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
        drv(0, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 1, 8'h99, 1, 0);
        drv(0, 0, 0, 8'h00, 0, 0, 8'h99, 0, 0);
        drv(0, 0, 1, 8'h3A, 0, 0, 8'h99, 0, 1);
        drv(0, 1, 1, 8'h55, 1, 0, 8'h00, 0, 0);
        drv(0, 0, 1, 8'h12, 0, 0, 8'h12, 0, 0);
        drv(0, 0, 0, 8'h00, 1, 1, 8'h12, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0);
        drv(0, 0, 1, 8'hA0, 0, 0, 8'h11, 0, 1);
        drv(0, 0, 1, 8'h9F, 0, 0, 8'h11, 0, 1);
        drv(0, 0, 1, 8'h09, 1, 0, 8'h09, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 0, 8'h09, 0, 0);

        // STEP_DIV=4: inc&dec does not advance the prescaler; load clears it.
        drv(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h02, 0, 0);
        drv(1, 0, 0, 8'h00, 0, 1, 8'h02, 0, 0);
        drv(1, 0, 0, 8'h00, 0, 1, 8'h02, 0, 0);
        drv(1, 0, 0, 8'h00, 0, 1, 8'h02, 0, 0);
        drv(1, 0, 0, 8'h00, 0, 1, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(1, 0, 1, 8'h50, 0, 0, 8'h50, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h50, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h50, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h50, 0, 0);
        drv(1, 0, 0, 8'h00, 1, 0, 8'h51, 0, 0);
        drv(1, 0, 0, 8'h00, 0, 0, 8'h51, 0, 0);

        // Asynchronous reset between clock edges while counts are non-zero.
        @(negedge clk);
        idle_all();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_count_a", {8'h0, cnt_a}, 16'h0000);
        check("async_rst_leds_a", {2'b0, leds_a}, {2'b0, model_leds(8'h00)});
        check("async_rst_count_b", {8'h0, cnt_b}, 16'h0000);
        check("async_rst_leds_b", {2'b0, leds_b}, {2'b0, model_leds(8'h00)});
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        drv(0, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0);
        drv(0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0);
        @(negedge clk);
        idle_all();
        repeat (3) @(posedge clk);
        #4;
        check("queues_drained", 16'(q_a.size() + q_b.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
